// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory APB controller.
// Holds the funct3 encodings, the FSM state type and the lane/strobe helper functions.
package dmem_ctrl_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_t;

  function automatic logic [3:0] strb_gen(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      SB:      return 4'b0001 << addr;
      SH:      return 4'b0011 << addr;
      SW:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Narrow stores place the datum on every lane so the strobes alone pick the target bytes.
  function automatic logic [31:0] wdata_rep(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      SB:      return {4{wdata[7:0]}};
      SH:      return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] addr,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {addr, 3'b000});
    h = 16'(word >> {addr[1], 4'b0000});
    case (funct3)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'b0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'b0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_apb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the favoured port when both request
// and flips to the other port after every grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~gnt[1];
    end
  end

endmodule

// File: rtl/dmem_apb_ctrl.sv
// Two-requester APB master for the data memory: arbitration, alignment checks,
// strobe/lane generation on stores and lane extraction with extension on loads.
module dmem_apb_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DMEM_W  = 11,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req_we_i,
  input  logic [1:0][31:0] req_addr_i,
  input  logic [1:0][31:0] req_wdata_i,
  input  logic [1:0][2:0]  req_funct3_i,
  output logic [1:0]       rsp_valid_o,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_err_o,
  output logic [DMEM_W-1:0] paddr_o,
  output logic             psel_o,
  output logic             penable_o,
  output logic             pwrite_o,
  output logic [31:0]      pwdata_o,
  output logic [3:0]       pstrb_o,
  output logic [2:0]       sel_mod_o,
  input  logic [31:0]      prdata_i,
  input  logic             pready_i
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t           state;
  logic             owner;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic [CNT_W-1:0] tmo_cnt;

  logic [1:0]  gnt;
  logic        grant_any;
  logic        gp;
  logic        g_we;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [2:0]  g_f3;
  logic        g_illegal;
  logic        g_misalign;
  logic        unused_addr_hi;

  assign sel_mod_o = 3'b010;

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req_valid_i),
    .advance (grant_any),
    .gnt     (gnt)
  );

  assign grant_any   = rst_ni && (state == S_IDLE) && (|req_valid_i);
  assign req_ready_o = grant_any ? gnt : 2'b00;

  assign gp             = gnt[1];
  assign g_we           = req_we_i[gp];
  assign g_addr         = req_addr_i[gp];
  assign g_wdata        = req_wdata_i[gp];
  assign g_f3           = req_funct3_i[gp];
  assign unused_addr_hi = ^g_addr[31:DMEM_W];

  always_comb begin
    g_illegal = 1'b1;
    case (g_f3)
      LB, LH, LW, LBU, LHU: g_illegal = g_we && g_f3[2];
      default:              g_illegal = 1'b1;
    endcase
    g_misalign = ((g_f3[1:0] == 2'b01) && g_addr[0]) ||
                 ((g_f3[1:0] == 2'b10) && (g_addr[1:0] != 2'b00));
  end

  // APB and response outputs are all registered; response fields default to zero every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      lo_q        <= 2'b00;
      tmo_cnt     <= '0;
      paddr_o     <= '0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= 32'h0;
      pstrb_o     <= 4'h0;
      rsp_valid_o <= 2'b00;
      rsp_rdata_o <= 32'h0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 2'b00;
      rsp_rdata_o <= 32'h0;
      rsp_err_o   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner   <= gp;
            we_q    <= g_we;
            f3_q    <= g_f3;
            lo_q    <= g_addr[1:0];
            tmo_cnt <= '0;
            if (g_illegal || g_misalign) begin
              state       <= S_ERR;
              rsp_valid_o <= gp ? 2'b10 : 2'b01;
              rsp_err_o   <= 1'b1;
            end else begin
              state    <= S_SETUP;
              psel_o   <= 1'b1;
              pwrite_o <= g_we;
              paddr_o  <= g_addr[DMEM_W-1:0];
              pstrb_o  <= g_we ? strb_gen(g_f3, g_addr[1:0]) : 4'h0;
              pwdata_o <= g_we ? wdata_rep(g_f3, g_wdata) : 32'h0;
            end
          end
        end
        S_SETUP: begin
          penable_o <= 1'b1;
          state     <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready_i || (tmo_cnt == CNT_W'(TIMEOUT - 1))) begin
            state       <= S_RESP;
            tmo_cnt     <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pstrb_o     <= 4'h0;
            pwdata_o    <= 32'h0;
            rsp_valid_o <= owner ? 2'b10 : 2'b01;
            rsp_err_o   <= !pready_i;
            rsp_rdata_o <= (pready_i && !we_q) ? load_ext(f3_q, lo_q, prdata_i) : 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: state <= S_IDLE;
        S_ERR:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_apb_ctrl.sv
// Scoreboard bench for dmem_apb_ctrl: drivers push expected APB setups and responses,
// monitors on the falling edge pop and compare them against what the DUT presents.
module tb_dmem_apb_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int DMEM_W  = 11;
  localparam int TIMEOUT = 16;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          gcyc;
  } rsp_exp_t;

  typedef struct {
    logic [10:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } apb_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld0 = 1'b0, vld1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wd0 = 32'h0, wd1 = 32'h0;
  logic [2:0]  f30 = 3'b0, f31 = 3'b0;

  logic [1:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][2:0]  req_f3;
  logic [31:0]      rsp_rdata, pwdata, prdata;
  logic             rsp_err, psel, penable, pwrite, pready;
  logic [DMEM_W-1:0] paddr;
  logic [3:0]       pstrb;
  logic [2:0]       sel_mod;

  assign req_valid = {vld1, vld0};
  assign req_we    = {we1, we0};
  assign req_addr  = {addr1, addr0};
  assign req_wdata = {wd1, wd0};
  assign req_f3    = {f31, f30};

  dmem_apb_ctrl #(.DMEM_W(DMEM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_funct3_i (req_f3),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .paddr_o      (paddr),
    .psel_o       (psel),
    .penable_o    (penable),
    .pwrite_o     (pwrite),
    .pwdata_o     (pwdata),
    .pstrb_o      (pstrb),
    .sel_mod_o    (sel_mod),
    .prdata_i     (prdata),
    .pready_i     (pready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wait_states = 0;
  int acc_cnt  = 0;

  rsp_exp_t rsp_q[$];
  apb_exp_t apb_q[$];
  int       grant_log[$];
  logic [31:0] mem [0:511];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endfunction

  function automatic void failNow(input string name);
    n_checks++;
    $display("[TB] FAIL %s: event seen but not allowed here", name);
  endfunction

  // Memory slave: holds pready low for wait_states ACCESS cycles, then completes.
  initial for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  always @(negedge clk) begin
    if (psel && penable) begin
      if (acc_cnt == wait_states) begin
        pready = 1'b1;
        prdata = mem[paddr[10:2]];
        if (pwrite)
          for (int b = 0; b < 4; b++)
            if (pstrb[b]) mem[paddr[10:2]][8*b +: 8] = pwdata[8*b +: 8];
      end else begin
        pready = 1'b0;
      end
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      prdata  = 32'h0;
      acc_cnt = 0;
    end
  end

  rsp_exp_t mon_e;
  apb_exp_t mon_a;
  logic [47:0] snap = 48'h0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid != 2'b00) begin
        if (rsp_q.size() == 0) failNow("rsp_unexpected");
        else begin
          mon_e = rsp_q.pop_front();
          checkOutput("rsp_port", 32'(rsp_valid), (mon_e.port == 1) ? 32'd2 : 32'd1);
          checkOutput("rsp_rdata", rsp_rdata, mon_e.rdata);
          checkOutput("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          checkOutput("rsp_latency", 32'(cyc - mon_e.gcyc), 32'(mon_e.lat));
          checkOutput("apb_idle_at_rsp", {30'b0, psel, penable}, 32'd0);
        end
      end else if (rsp_rdata != 32'h0 || rsp_err) begin
        failNow("rsp_fields_without_valid");
      end
      if (psel && !penable) begin
        if (apb_q.size() == 0) failNow("apb_unexpected_setup");
        else begin
          mon_a = apb_q.pop_front();
          snap  = {paddr, pwrite, pstrb, pwdata};
          checkOutput("apb_paddr", 32'(paddr), 32'(mon_a.addr));
          checkOutput("apb_pwrite", 32'(pwrite), 32'(mon_a.wr));
          checkOutput("apb_pstrb", 32'(pstrb), 32'(mon_a.strb));
          checkOutput("apb_pwdata", pwdata, mon_a.wdata);
        end
      end
      if (penable && !psel) failNow("apb_enable_without_sel");
      if (psel && penable && ({paddr, pwrite, pstrb, pwdata} != snap)) failNow("apb_unstable");
    end
  end

  task automatic setPort(input int p, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
    if (p == 0) begin
      vld0 = v; we0 = we; addr0 = a; wd0 = wd; f30 = f3;
    end else begin
      vld1 = v; we1 = we; addr1 = a; wd1 = wd; f31 = f3;
    end
  endtask

  // Call at a falling edge; returns at the falling edge after the handshake.
  task automatic applyStimulus(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input logic [3:0] exp_strb, input logic [31:0] exp_pw,
                               input bit expect_rsp);
    int budget;
    rsp_exp_t e;
    apb_exp_t x;
    budget = 0;
    setPort(p, 1'b1, we, a, wd, f3);
    forever begin
      #1;
      if (req_ready[p]) break;
      budget++;
      if (budget > 200) break;
      @(negedge clk);
    end
    if (req_ready[p]) begin
      grant_log.push_back(p);
      e.port = p; e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.gcyc = cyc;
      if (expect_rsp) rsp_q.push_back(e);
      x.addr = a[10:0]; x.wr = we; x.strb = exp_strb; x.wdata = exp_pw;
      if (exp_lat != 1) apb_q.push_back(x);
      @(posedge clk);
    end else begin
      failNow("grant_timeout");
    end
    @(negedge clk);
    setPort(p, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while ((rsp_q.size() != 0 || apb_q.size() != 0) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) failNow("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic checkGrants(input int g0, input int g1, input int g2, input int g3, input int n);
    int exp_g[4];
    exp_g = '{g0, g1, g2, g3};
    checkOutput("grant_count", 32'(grant_log.size()), 32'(n));
    for (int i = 0; i < n && i < grant_log.size(); i++)
      checkOutput("grant_order", 32'(grant_log[i]), 32'(exp_g[i]));
    grant_log.delete();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    repeat (3) @(negedge clk);
    checkOutput("reset_psel", 32'(psel), 32'd0);
    checkOutput("reset_penable", 32'(penable), 32'd0);
    checkOutput("reset_pwrite", 32'(pwrite), 32'd0);
    checkOutput("reset_paddr", 32'(paddr), 32'd0);
    checkOutput("reset_pwdata", pwdata, 32'd0);
    checkOutput("reset_pstrb", 32'(pstrb), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_sel_mod", 32'(sel_mod), 32'h2);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] arbitration, both ports valid");
    fork
      begin
        applyStimulus(0, 1'b1, 32'h40, 32'h11111111, SW, 32'h0, 1'b0, 3, 4'hF, 32'h11111111, 1'b1);
        applyStimulus(0, 1'b0, 32'h40, 32'h0, LW, 32'h11111111, 1'b0, 3, 4'h0, 32'h0, 1'b1);
      end
      begin
        applyStimulus(1, 1'b1, 32'h80, 32'h22222222, SW, 32'h0, 1'b0, 3, 4'hF, 32'h22222222, 1'b1);
        applyStimulus(1, 1'b0, 32'h80, 32'h0, LW, 32'h22222222, 1'b0, 3, 4'h0, 32'h0, 1'b1);
      end
    join
    waitDrain();
    checkGrants(0, 1, 0, 1, 4);

    $display("[TB] word store/load and lane extraction on port 0");
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, SW, 32'h0, 1'b0, 3, 4'hF, 32'hDEADBEEF, 1'b1);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, LW,  32'hDEADBEEF, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 32'h13, 32'h0, LB,  32'hFFFFFFDE, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 32'h13, 32'h0, LBU, 32'h000000DE, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 32'h12, 32'h0, LH,  32'hFFFFDEAD, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, LHU, 32'h0000BEEF, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, LB,  32'hFFFFFFEF, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 32'h11, 32'h0, LBU, 32'h000000BE, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 32'h11, 32'h00000055, SB, 32'h0, 1'b0, 3, 4'b0010, 32'h55555555, 1'b1);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, LW,  32'hDEAD55EF, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 32'h12, 32'hABCD1234, SH, 32'h0, 1'b0, 3, 4'b1100, 32'h12341234, 1'b1);
    applyStimulus(1, 1'b0, 32'h10, 32'h0, LW,  32'h123455EF, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    waitDrain();
    grant_log.delete();

    $display("[TB] misaligned and illegal requests");
    applyStimulus(0, 1'b0, 32'h2, 32'h0, LW, 32'h0, 1'b1, 1, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 32'h5, 32'h0000BEEF, SH, 32'h0, 1'b1, 1, 4'h0, 32'h0, 1'b1);
    applyStimulus(1, 1'b0, 32'h3, 32'h0, LHU, 32'h0, 1'b1, 1, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 1, 4'h0, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1, 1, 4'h0, 32'h0, 1'b1);
    waitDrain();
    grant_log.delete();

    $display("[TB] wait states and timeout");
    wait_states = 3;
    applyStimulus(0, 1'b0, 32'h10, 32'h0, LW, 32'h123455EF, 1'b0, 6, 4'h0, 32'h0, 1'b1);
    waitDrain();
    wait_states = 1000;
    applyStimulus(1, 1'b0, 32'h10, 32'h0, LW, 32'h0, 1'b1, TIMEOUT + 2, 4'h0, 32'h0, 1'b1);
    budget = 0;
    while (rsp_q.size() != 0 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 60) failNow("timeout_rsp_missing");
    checkOutput("timeout_penable_low", 32'(penable), 32'd0);
    waitDrain();
    grant_log.delete();

    $display("[TB] reset during ACCESS");
    applyStimulus(0, 1'b0, 32'h10, 32'h0, LW, 32'h0, 1'b0, 3, 4'h0, 32'h0, 1'b0);
    budget = 0;
    while (!penable && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("pre_reset_penable", 32'(penable), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_psel", 32'(psel), 32'd0);
    checkOutput("async_reset_penable", 32'(penable), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    wait_states = 0;
    grant_log.delete();
    @(negedge clk);
    fork
      applyStimulus(0, 1'b0, 32'h40, 32'h0, LW, 32'h11111111, 1'b0, 3, 4'h0, 32'h0, 1'b1);
      applyStimulus(1, 1'b0, 32'h80, 32'h0, LW, 32'h22222222, 1'b0, 3, 4'h0, 32'h0, 1'b1);
    join
    waitDrain();
    checkGrants(0, 1, 0, 0, 2);

    checkOutput("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    checkOutput("apb_queue_empty", 32'(apb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_apb_ctrl.md
Name: dmem_apb_ctrl

Overview:
- Two-requester APB master that shares the data memory between the pipeline LSU (port 0) and a debug/DMA loader (port 1).
- Arbitrates between the requesters and checks alignment.
- Drives the APB setup and access phases.
- Generates byte strobes and lane-replicated write data.
- Performs load lane extraction and sign/zero extension itself; the memory is always read in word mode.

Parameters:
DMEM_W, 11, byte-address width of the data memory (2 KB)
TIMEOUT, 16, max ACCESS-phase cycles waiting for pready_i before abort (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  2  per-requester request valid, bit n = port n
req_ready_o  out  2  request accepted this cycle (one-hot or zero)
req_we_i  in  2  1 = store, 0 = load
req_addr_i  in  2x32  byte address, packed [1:0][31:0]
req_wdata_i  in  2x32  store data, right-aligned
req_funct3_i  in  2x3  inst[14:12]: 000 b, 001 h, 010 w, 100 bu, 101 hu
rsp_valid_o  out  2  one-cycle response pulse to the owning port
rsp_rdata_o  out  32  extended load data, 0 for stores and errors
rsp_err_o  out  1  misaligned, illegal funct3, or timeout
paddr_o  out  DMEM_W  APB address
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write
pwdata_o  out  32  APB write data
pstrb_o  out  4  APB byte strobes
sel_mod_o  out  3  memory read mode, constant 3'b010
prdata_i  in  32  APB read data (raw word)
pready_i  in  1  APB ready

Behaviour:
- Reset values:
  - FSM in IDLE.
  - All outputs 0 except sel_mod_o = 3'b010.
  - Round-robin pointer = port 0.
  - Timeout counter 0.
- Reset mid-transfer aborts immediately: psel_o/penable_o drop asynchronously and no response is issued.
- FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE, plus IDLE -> ERR -> IDLE.
- IDLE:
  - If any req_valid_i is set, grant one port and pulse its req_ready_o for that cycle.
  - The granted request's fields are latched.
  - If only one port is valid, grant it.
  - If both are valid, grant the port the round-robin pointer names.
  - After each grant the pointer moves to the other port.
- Checks at grant:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - funct3 outside {000,001,010,100,101} is illegal.
  - A store with funct3[2]=1 is illegal.
  - Any of these -> ERR. No APB activity occurs.
- SETUP (1 cycle): psel_o=1, penable_o=0, paddr_o = latched addr[DMEM_W-1:0], pwrite_o = we.
- Strobes, stores:
  - sb -> pstrb_o = 4'b0001 << addr[1:0]
  - sh -> 4'b0011 << addr[1:0]
  - sw -> 4'b1111
  - Loads drive pstrb_o = 0.
- pwdata_o lane replication:
  - sb -> {4{wdata[7:0]}}
  - sh -> {2{wdata[15:0]}}
  - sw -> wdata
- APB outputs hold stable from SETUP through ACCESS.
- ACCESS: psel_o=1, penable_o=1.
  - On pready_i=1: capture prdata_i and go to RESP.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT-1 without pready_i: go to RESP with err=1.
  - APB signals deassert on exit from ACCESS.
- Load extraction (in RESP):
  - byte = word >> (8*addr[1:0])
  - half = word >> (16*addr[1])
  - Sign- or zero-extend per funct3[2].
- RESP (1 cycle): rsp_valid_o[owner]=1 with rdata/err, then IDLE. Store responses carry rdata=0, err=0.
- ERR (1 cycle): rsp_valid_o[owner]=1, rsp_err_o=1, rdata=0.
- Minimum latency, grant to rsp_valid_o: 3 cycles (SETUP, ACCESS with pready_i=1, RESP). An error is reported 1 cycle after grant.
- Back-to-back throughput: one transaction per 4 cycles with zero-wait memory.
- Requester rules:
  - A requester must hold valid and its fields stable until ready.
  - Dropping valid before ready is legal and has no effect.
  - Requests arriving in states other than IDLE wait; req_ready_o=0.
- rsp_rdata_o/rsp_err_o are 0 whenever rsp_valid_o=0.

Decomposition:
- Package dmem_ctrl_pkg:
  - funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - State enum typedef.
  - Function strb_gen(funct3, addr[1:0]).
  - Function load_ext(funct3, addr[1:0], word).
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter with its pointer register, update on grant.

Test Plan:
- Single store then load on port 0:
  - sw 0xDEADBEEF @0x10 -> pstrb_o=1111, response err=0.
  - lw @0x10 -> rsp_rdata_o=0xDEADBEEF, 3 cycles after grant.
- Byte/half lanes:
  - After the word above, lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD.
  - sb 0x55 @0x11 -> pstrb_o=0010, pwdata_o=0x55555555.
- Arbitration: both ports valid continuously for 4 transactions -> grants alternate 0,1,0,1; no APB overlap; each port receives exactly its own responses.
- Misalignment: lw @0x2 and sh @0x5 -> psel_o never asserted, rsp_err_o=1 one cycle after grant; illegal funct3 011 -> err.
- Wait states/timeout:
  - pready_i low 3 cycles -> response with correct data at cycle 6 after grant.
  - pready_i held low -> err after TIMEOUT ACCESS cycles and penable_o drops.
- Reset mid-ACCESS: assert rst_ni low -> psel_o/penable_o 0 immediately, no rsp_valid_o; the next request after release proceeds normally from port 0.
